// File: rtl/vdp_pkg.sv
// Shared constants for the VDP CPU port: mode codes, register indices,
// status bit positions, control opcodes and the first-byte latch state.
package vdp_pkg;

  localparam int VRAM_AW = 14;

  localparam logic [2:0] MODE_TEXT = 3'd0;
  localparam logic [2:0] MODE_G1   = 3'd1;
  localparam logic [2:0] MODE_G2   = 3'd2;
  localparam logic [2:0] MODE_MC   = 3'd3;

  localparam logic [3:0] REG_MODE0    = 4'd0;
  localparam logic [3:0] REG_MODE1    = 4'd1;
  localparam logic [3:0] REG_NAME     = 4'd2;
  localparam logic [3:0] REG_COLOR    = 4'd3;
  localparam logic [3:0] REG_FONT     = 4'd4;
  localparam logic [3:0] REG_SPR_ATTR = 4'd5;
  localparam logic [3:0] REG_SPR_PAT  = 4'd6;
  localparam logic [3:0] REG_COLOURS  = 4'd7;
  localparam logic [3:0] REG_XSCROLL  = 4'd8;
  localparam logic [3:0] REG_YSCROLL  = 4'd9;
  localparam logic [3:0] REG_R10      = 4'd10;

  localparam int STAT_F  = 7;
  localparam int STAT_5S = 6;
  localparam int STAT_C  = 5;

  // Only bit 7 matters for a register write; bit 6 is don't-care.
  localparam logic [1:0] OP_READ_SETUP  = 2'b00;
  localparam logic [1:0] OP_WRITE_SETUP = 2'b01;
  localparam logic [1:0] OP_REG_WRITE   = 2'b10;

  typedef enum logic {
    LATCH_EMPTY = 1'b0,
    LATCH_FULL  = 1'b1
  } latch_state_t;

  // M1 has priority over M3, which has priority over M2.
  function automatic logic [2:0] decode_mode(input logic m1, input logic m2, input logic m3);
    logic [2:0] m;
    if (m1) begin
      m = MODE_TEXT;
    end else if (m3) begin
      m = MODE_G2;
    end else if (m2) begin
      m = MODE_MC;
    end else begin
      m = MODE_G1;
    end
    return m;
  endfunction

endpackage

// File: rtl/vdp_reg_decode.sv
// Combinational mapping from VDP registers R0..R7 to the mode code, table
// bases, sprite/display flags and colours consumed by the video stage.
module vdp_reg_decode
  import vdp_pkg::*;
(
  input  logic [7:0]         r0,
  input  logic [7:0]         r1,
  input  logic [7:0]         r2,
  input  logic [7:0]         r3,
  input  logic [7:0]         r4,
  input  logic [7:0]         r5,
  input  logic [7:0]         r6,
  input  logic [7:0]         r7,
  output logic [2:0]         mode,
  output logic [VRAM_AW-1:0] name_table_addr,
  output logic [VRAM_AW-1:0] color_table_addr,
  output logic [VRAM_AW-1:0] font_addr,
  output logic [VRAM_AW-1:0] sprite_attr_addr,
  output logic [VRAM_AW-1:0] sprite_pattern_table_addr,
  output logic               video_on,
  output logic               vert_retrace_int,
  output logic               sprite_large,
  output logic               sprite_enlarged,
  output logic [3:0]         text_color,
  output logic [3:0]         back_color
);

  logic [2:0] mode_dec;
  logic       unused_bits;

  assign unused_bits = ^{r0[7:2], r0[0], r1[7], r1[2], r2[7:4], r4[7:3], r5[7], r6[7:3]};

  // Register fields to video-stage controls; graphics II uses coarse colour/font bases.
  always_comb begin
    mode_dec                  = decode_mode(r1[4], r1[3], r0[1]);
    mode                      = mode_dec;
    name_table_addr           = {r2[3:0], 10'b0};
    sprite_attr_addr          = {r5[6:0], 7'b0};
    sprite_pattern_table_addr = {r6[2:0], 11'b0};
    video_on                  = r1[6];
    vert_retrace_int          = r1[5];
    sprite_large              = r1[1];
    sprite_enlarged           = r1[0];
    text_color                = r7[7:4];
    back_color                = r7[3:0];
    color_table_addr          = {r3, 6'b0};
    font_addr                 = {r4[2:0], 11'b0};
    if (mode_dec == MODE_G2) begin
      color_table_addr = {r3[7], 13'b0};
      font_addr        = {r4[2], 13'b0};
    end else begin
      color_table_addr = {r3, 6'b0};
      font_addr        = {r4[2:0], 11'b0};
    end
  end

endmodule

// File: rtl/vdp_port_ctrl.sv
// VDP CPU port front end: control/data port protocol, VRAM pointer, read-ahead
// buffer, register file and status. Define SMS_REGS_EN to implement R8..R10.
module vdp_port_ctrl
  import vdp_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int NUM_REGS = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              port_sel,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_wr,
  output logic              vram_rd,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata,
  output logic [2:0]        mode,
  output logic [ADDR_W-1:0] name_table_addr,
  output logic [ADDR_W-1:0] color_table_addr,
  output logic [ADDR_W-1:0] font_addr,
  output logic [ADDR_W-1:0] sprite_attr_addr,
  output logic [ADDR_W-1:0] sprite_pattern_table_addr,
  output logic              video_on,
  output logic              vert_retrace_int,
  output logic              sprite_large,
  output logic              sprite_enlarged,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  output logic [7:0]        x_scroll,
  output logic [7:0]        y_scroll,
  input  logic              interrupt_flag,
  input  logic              sprite_collision,
  input  logic              too_many_sprites,
  input  logic [4:0]        sprite5
);

`ifdef SMS_REGS_EN
  localparam int REG_CNT = NUM_REGS;
`else
  localparam int REG_CNT = 8;
`endif

  latch_state_t      latch;
  logic [7:0]        lo_byte;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rbuf;
  logic              cap;
  logic              irq_f;
  logic              fifth_f;
  logic              coll_f;
  logic [4:0]        s5;
  logic [7:0]        regs [REG_CNT];
  logic              status_clr;

  assign vram_addr  = addr;
  assign status_clr = cpu_rd & port_sel & ~cpu_wr;

  // Port protocol, address pointer, prefetch pipeline and register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch      <= LATCH_EMPTY;
      lo_byte    <= 8'h00;
      addr       <= '0;
      rbuf       <= 8'h00;
      cap        <= 1'b0;
      cpu_dout   <= 8'h00;
      vram_wr    <= 1'b0;
      vram_rd    <= 1'b0;
      vram_wdata <= 8'h00;
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      vram_wr <= 1'b0;
      vram_rd <= 1'b0;
      cap     <= vram_rd;
      // The pointer advances during the access cycle so a back-to-back access sees the next address.
      if (vram_rd || vram_wr) begin
        addr <= addr + ADDR_W'(1);
      end
      if (cap) begin
        rbuf <= vram_rdata;
      end
      if (cpu_wr) begin
        if (port_sel) begin
          case (latch)
            LATCH_EMPTY: begin
              lo_byte <= cpu_din;
              latch   <= LATCH_FULL;
            end
            LATCH_FULL: begin
              latch <= LATCH_EMPTY;
              case (cpu_din[7:6])
                OP_READ_SETUP: begin
                  addr    <= {cpu_din[5:0], lo_byte};
                  vram_rd <= 1'b1;
                end
                OP_WRITE_SETUP: begin
                  addr <= {cpu_din[5:0], lo_byte};
                end
                default: begin
                  for (int i = 0; i < REG_CNT; i++) begin
                    if (cpu_din[3:0] == 4'(i)) begin
                      regs[i] <= lo_byte;
                    end
                  end
                end
              endcase
            end
            default: latch <= LATCH_EMPTY;
          endcase
        end else begin
          vram_wr    <= 1'b1;
          vram_wdata <= cpu_din;
          rbuf       <= cpu_din;
          latch      <= LATCH_EMPTY;
        end
      end else if (cpu_rd) begin
        latch <= LATCH_EMPTY;
        if (port_sel) begin
          cpu_dout <= {irq_f, fifth_f, coll_f, s5};
        end else begin
          cpu_dout <= cap ? vram_rdata : rbuf;
          vram_rd  <= 1'b1;
        end
      end
    end
  end

  // Status flags: a set in the same cycle as a status read wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_f   <= 1'b0;
      fifth_f <= 1'b0;
      coll_f  <= 1'b0;
      s5      <= 5'h00;
    end else begin
      irq_f   <= interrupt_flag   | (irq_f   & ~status_clr);
      coll_f  <= sprite_collision | (coll_f  & ~status_clr);
      fifth_f <= too_many_sprites | (fifth_f & ~status_clr);
      if (too_many_sprites && (!fifth_f || status_clr)) begin
        s5 <= sprite5;
      end else if (status_clr) begin
        s5 <= 5'h1f;
      end
    end
  end

`ifdef SMS_REGS_EN
  logic unused_r10;
  assign unused_r10 = ^regs[REG_CNT-1];
  assign x_scroll   = regs[8];
  assign y_scroll   = regs[9];
`else
  assign x_scroll = 8'h00;
  assign y_scroll = 8'h00;
`endif

  vdp_reg_decode u_decode (
    .r0                        (regs[0]),
    .r1                        (regs[1]),
    .r2                        (regs[2]),
    .r3                        (regs[3]),
    .r4                        (regs[4]),
    .r5                        (regs[5]),
    .r6                        (regs[6]),
    .r7                        (regs[7]),
    .mode                      (mode),
    .name_table_addr           (name_table_addr),
    .color_table_addr          (color_table_addr),
    .font_addr                 (font_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .video_on                  (video_on),
    .vert_retrace_int          (vert_retrace_int),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .text_color                (text_color),
    .back_color                (back_color)
  );

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Directed bench for vdp_port_ctrl with a small VRAM model; expected values
// are hand-derived from the port protocol.
module tb_vdp_port_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        port_sel = 1'b0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic [13:0] vram_addr;
  logic        vram_wr;
  logic        vram_rd;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [2:0]  mode;
  logic [13:0] name_table_addr, color_table_addr, font_addr;
  logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
  logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
  logic [3:0]  text_color, back_color;
  logic [7:0]  x_scroll, y_scroll;
  logic        interrupt_flag = 1'b0;
  logic        sprite_collision = 1'b0;
  logic        too_many_sprites = 1'b0;
  logic [4:0]  sprite5 = 5'h00;

  logic [7:0]  mem [16384];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  vdp_port_ctrl dut (
    .clk(clk), .reset(reset), .port_sel(port_sel), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vram_addr(vram_addr), .vram_wr(vram_wr),
    .vram_rd(vram_rd), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .mode(mode),
    .name_table_addr(name_table_addr), .color_table_addr(color_table_addr),
    .font_addr(font_addr), .sprite_attr_addr(sprite_attr_addr),
    .sprite_pattern_table_addr(sprite_pattern_table_addr), .video_on(video_on),
    .vert_retrace_int(vert_retrace_int), .sprite_large(sprite_large),
    .sprite_enlarged(sprite_enlarged), .text_color(text_color), .back_color(back_color),
    .x_scroll(x_scroll), .y_scroll(y_scroll), .interrupt_flag(interrupt_flag),
    .sprite_collision(sprite_collision), .too_many_sprites(too_many_sprites),
    .sprite5(sprite5)
  );

  // VRAM model: read data appears the cycle after vram_rd; preloaded during reset.
  always @(posedge clk) begin
    if (reset) begin
      mem[14'h0100] <= 8'h11;
      mem[14'h0101] <= 8'h22;
      mem[14'h0102] <= 8'h33;
      mem[14'h0200] <= 8'h5A;
      mem[14'h0201] <= 8'h6B;
      vram_rdata    <= 8'h00;
    end else begin
      if (vram_wr) mem[vram_addr] <= vram_wdata;
      if (vram_rd) vram_rdata <= mem[vram_addr];
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All strobe tasks start and end on a falling edge.
  task automatic ctrl_wr(input logic [7:0] b);
    port_sel = 1'b1; cpu_wr = 1'b1; cpu_din = b;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic data_wr(input logic [7:0] b);
    port_sel = 1'b0; cpu_wr = 1'b1; cpu_din = b;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic ctrl_rd();
    port_sel = 1'b1; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  task automatic data_rd();
    port_sel = 1'b0; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  task automatic reg_wr(input logic [3:0] idx, input logic [7:0] val);
    ctrl_wr(val);
    ctrl_wr({4'h8, idx});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_mode", 16'(mode), 16'd1);
    check("rst_video_on", 16'(video_on), 16'd0);
    check("rst_dout", 16'(cpu_dout), 16'h00);
    check("rst_vram_wr", 16'(vram_wr), 16'd0);
    check("rst_vram_rd", 16'(vram_rd), 16'd0);
    check("rst_addr", 16'(vram_addr), 16'h0000);

    reg_wr(4'd7, 8'h00);
    check("r7_text0", 16'(text_color), 16'h0);
    check("r7_back0", 16'(back_color), 16'h0);
    reg_wr(4'd7, 8'hF4);
    check("r7_text", 16'(text_color), 16'hF);
    check("r7_back", 16'(back_color), 16'h4);

    ctrl_wr(8'h34); ctrl_wr(8'h52);
    data_wr(8'hAA);
    check("wr1_strobe", 16'(vram_wr), 16'd1);
    check("wr1_addr", 16'(vram_addr), 16'h1234);
    check("wr1_data", 16'(vram_wdata), 16'h00AA);
    data_wr(8'hBB);
    check("wr2_strobe", 16'(vram_wr), 16'd1);
    check("wr2_addr", 16'(vram_addr), 16'h1235);
    check("wr2_data", 16'(vram_wdata), 16'h00BB);
    @(negedge clk);
    check("wr_strobe_drop", 16'(vram_wr), 16'd0);
    check("wr_ptr_after", 16'(vram_addr), 16'h1236);
    data_rd();
    check("rbuf_from_write", 16'(cpu_dout), 16'h00BB);
    repeat (3) @(negedge clk);

    ctrl_wr(8'h00); ctrl_wr(8'h01);
    check("rsetup_rd_strobe", 16'(vram_rd), 16'd1);
    check("rsetup_addr", 16'(vram_addr), 16'h0100);
    repeat (2) @(negedge clk);
    data_rd();
    check("rd1_dout", 16'(cpu_dout), 16'h0011);
    repeat (2) @(negedge clk);
    data_rd();
    check("rd2_dout", 16'(cpu_dout), 16'h0022);
    repeat (3) @(negedge clk);
    check("rd_ptr_end", 16'(vram_addr), 16'h0103);

    // Read strobe lands exactly in the prefetch capture cycle.
    ctrl_wr(8'h00); ctrl_wr(8'h02);
    @(negedge clk);
    data_rd();
    check("rd_bypass", 16'(cpu_dout), 16'h005A);
    repeat (3) @(negedge clk);

    interrupt_flag = 1'b1;
    @(negedge clk);
    interrupt_flag = 1'b0; sprite_collision = 1'b1;
    @(negedge clk);
    sprite_collision = 1'b0;
    ctrl_rd();
    check("stat_f_c", 16'(cpu_dout), 16'h00A0);
    ctrl_rd();
    check("stat_cleared", 16'(cpu_dout), 16'h001F);

    too_many_sprites = 1'b1; sprite5 = 5'd9;
    @(negedge clk);
    too_many_sprites = 1'b0; sprite5 = 5'd3;
    ctrl_rd();
    check("stat_5s", 16'(cpu_dout), 16'h0049);
    ctrl_rd();
    check("stat_5s_cleared", 16'(cpu_dout), 16'h001F);

    interrupt_flag = 1'b1;
    ctrl_rd();
    interrupt_flag = 1'b0;
    check("set_wins_rd", 16'(cpu_dout), 16'h001F);
    ctrl_rd();
    check("set_wins_kept", 16'(cpu_dout), 16'h009F);

    ctrl_wr(8'h55);
    ctrl_rd();
    ctrl_wr(8'h81); ctrl_wr(8'h80);
    check("latch_rd_mode", 16'(mode), 16'd1);
    check("latch_rd_video", 16'(video_on), 16'd0);

    reg_wr(4'd1, 8'h10);
    check("mode_text", 16'(mode), 16'd0);
    reg_wr(4'd1, 8'h08);
    check("mode_mc", 16'(mode), 16'd3);
    reg_wr(4'd1, 8'h63);
    check("mode_g1", 16'(mode), 16'd1);
    check("r1_flags", 16'({video_on, vert_retrace_int, sprite_large, sprite_enlarged}), 16'hF);
    reg_wr(4'd0, 8'h02);
    check("mode_g2", 16'(mode), 16'd2);
    reg_wr(4'd3, 8'hFF);
    reg_wr(4'd4, 8'h07);
    check("g2_color", 16'(color_table_addr), 16'h2000);
    check("g2_font", 16'(font_addr), 16'h2000);
    reg_wr(4'd0, 8'h00);
    check("g1_color", 16'(color_table_addr), 16'h3FC0);
    check("g1_font", 16'(font_addr), 16'h3800);
    reg_wr(4'd2, 8'h0F);
    check("name_base", 16'(name_table_addr), 16'h3C00);
    reg_wr(4'd5, 8'h7F);
    check("spr_attr_base", 16'(sprite_attr_addr), 16'h3F80);
    reg_wr(4'd6, 8'h07);
    check("spr_pat_base", 16'(sprite_pattern_table_addr), 16'h3800);
    reg_wr(4'd15, 8'h10);
    check("reg_idx_ignored", 16'(mode), 16'd1);

    reg_wr(4'd8, 8'h12);
    reg_wr(4'd9, 8'h34);
`ifdef SMS_REGS_EN
    check("x_scroll", 16'(x_scroll), 16'h0012);
    check("y_scroll", 16'(y_scroll), 16'h0034);
`else
    check("x_scroll", 16'(x_scroll), 16'h0000);
    check("y_scroll", 16'(y_scroll), 16'h0000);
`endif

    ctrl_wr(8'hFF); ctrl_wr(8'h7F);
    data_wr(8'h01);
    check("wrap_addr_top", 16'(vram_addr), 16'h3FFF);
    data_wr(8'h02);
    check("wrap_addr_zero", 16'(vram_addr), 16'h0000);
    check("wrap_wr_strobe", 16'(vram_wr), 16'd1);
    @(negedge clk);

    ctrl_wr(8'h34);
    do_reset();
    check("midrst_mode", 16'(mode), 16'd1);
    ctrl_wr(8'h00); ctrl_wr(8'h47);
    check("midrst_addr", 16'(vram_addr), 16'h0700);
    check("midrst_no_rd", 16'(vram_rd), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
